// File: rtl/npc_pkg.sv
// Shared encodings and BTB entry types for the next-PC predictor.
// No logic of its own; pure types, constants and counter helpers.
// Not applicable (package only).
package npc_pkg;

  // EX branch codes; bit0 set marks a conditional branch
  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b011;
  localparam logic [2:0] BR_BLT = 3'b101;
  localparam logic [2:0] BR_BGE = 3'b111;

  // EX jump field: bit0 means any unconditional jump, 2'b01 is jalr
  localparam logic [1:0] J_ANY  = 2'b01;
  localparam logic [1:0] J_JALR = 2'b01;

  // 2-bit saturating counter; msb set predicts taken
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Resettable part of a BTB entry; tag and target live in plain arrays
  typedef struct packed {
    logic valid;
    logic is_jump;
    ctr_e ctr;
  } btb_state_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      CTR_SNT: return CTR_WNT;
      CTR_WNT: return CTR_WT;
      default: return CTR_ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      CTR_ST:  return CTR_WT;
      CTR_WT:  return CTR_WNT;
      default: return CTR_SNT;
    endcase
  endfunction

endpackage

// File: rtl/npc_resolve.sv
// Resolves actual branch/jump outcome and target from EX-stage operands.
// Latency: zero, purely combinational.
// Backpressure: none; follows its inputs every cycle.
module npc_resolve
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      ex_branch,
  input  logic [1:0]      ex_jump,
  input  logic            ex_zero,
  input  logic            ex_sgn,
  input  logic [XLEN-1:0] ex_pc_imm,
  input  logic [XLEN-1:0] ex_alu_c,
  output logic            act_taken,
  output logic [XLEN-1:0] act_target
);

  // jalr target has its lsb forced clear, everything else uses pc+imm
  localparam logic [XLEN-1:0] LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};

  // Outcome and destination of the EX instruction
  always_comb begin
    act_taken = 1'b0;
    if ((ex_jump & J_ANY) != 2'b00) begin
      act_taken = 1'b1;
    end else begin
      case (ex_branch)
        BR_BEQ:  act_taken = ex_zero;
        BR_BNE:  act_taken = !ex_zero;
        BR_BLT:  act_taken = ex_sgn;
        BR_BGE:  act_taken = !ex_sgn;
        default: act_taken = 1'b0;
      endcase
    end
    act_target = (ex_jump == J_JALR) ? (ex_alu_c & LSB_CLR) : ex_pc_imm;
  end

endmodule

// File: rtl/npc_predictor.sv
// Next-PC predictor: direct-mapped BTB lookup in IF, resolve/redirect/train in EX.
// Latency: lookup and redirect combinational; table writes at the next rising edge.
// Backpressure: ex_stall holds training off (redirect still follows inputs). Optional NPC_STATS_EN adds counters.
module npc_predictor
  import npc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_branch,
  input  logic [1:0]      ex_jump,
  input  logic            ex_zero,
  input  logic            ex_sgn,
  input  logic [XLEN-1:0] ex_pc_imm,
  input  logic [XLEN-1:0] ex_alu_c,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef NPC_STATS_EN
  ,
  output logic [31:0]     stat_ctl,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  btb_state_t             st_q     [ENTRIES];
  logic [TAG_W-1:0]       tag_q    [ENTRIES];
  logic [XLEN-1:0]        target_q [ENTRIES];

  logic [IDX-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_state_t       if_st, ex_st;
  logic             if_hit, ex_hit;
  logic             act_taken;
  logic [XLEN-1:0]  act_target;
  logic             update;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[XLEN-1:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX+2];

  npc_resolve #(.XLEN(XLEN)) u_resolve (
    .ex_branch  (ex_branch),
    .ex_jump    (ex_jump),
    .ex_zero    (ex_zero),
    .ex_sgn     (ex_sgn),
    .ex_pc_imm  (ex_pc_imm),
    .ex_alu_c   (ex_alu_c),
    .act_taken  (act_taken),
    .act_target (act_target)
  );

  // IF lookup, EX hit check, mispredict detection and training qualifier
  always_comb begin
    if_st       = st_q[if_idx];
    if_hit      = if_st.valid && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && (if_st.is_jump || if_st.ctr[1]);
    pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

    ex_st       = st_q[ex_idx];
    ex_hit      = ex_st.valid && (tag_q[ex_idx] == ex_tag);
    redirect    = ex_valid && ((act_taken != ex_pred_taken) ||
                               (act_taken && (act_target != ex_pred_target)));
    redirect_pc = act_taken ? act_target : ex_pc + XLEN'(4);
    update      = ex_valid && !ex_stall && (ex_jump[0] || ex_branch[0]);
  end

  // Entry state: allocate or strengthen on taken, weaken on not-taken hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= '0;
    end else if (update) begin
      if (act_taken) begin
        if (ex_hit) begin
          st_q[ex_idx] <= '{valid: 1'b1, is_jump: ex_jump[0], ctr: ctr_inc(ex_st.ctr)};
        end else begin
          st_q[ex_idx] <= '{valid: 1'b1, is_jump: ex_jump[0],
                            ctr: (ex_jump[0] ? CTR_ST : CTR_WT)};
        end
      end else if (ex_hit) begin
        st_q[ex_idx].ctr <= ctr_dec(ex_st.ctr);
      end
    end
  end

  // Tag and target are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (update && act_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= act_target;
    end
  end

`ifdef NPC_STATS_EN
  // Control-flow and mispredict counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ctl     <= '0;
      stat_mispred <= '0;
    end else if (update) begin
      stat_ctl <= stat_ctl + 32'd1;
      if (redirect) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_predictor.sv
// Directed bench for npc_predictor with hand-computed expectations.
// Latency: checks combinational outputs 1ns after driving, state after each clock.
// Backpressure: exercises ex_stall holding off training.
module tb_npc_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_stall;
  logic [31:0] ex_pc;
  logic [2:0]  ex_branch;
  logic [1:0]  ex_jump;
  logic        ex_zero, ex_sgn;
  logic [31:0] ex_pc_imm, ex_alu_c;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef NPC_STATS_EN
  logic [31:0] stat_ctl, stat_mispred;
  logic [31:0] ctl0, mis0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  npc_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_zero        (ex_zero),
    .ex_sgn         (ex_sgn),
    .ex_pc_imm      (ex_pc_imm),
    .ex_alu_c       (ex_alu_c),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef NPC_STATS_EN
    ,
    .stat_ctl       (stat_ctl),
    .stat_mispred   (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one EX instruction; settle 1ns for combinational outputs
  task automatic set_ex(input logic v, input logic s, input logic [31:0] pc,
                        input logic [2:0] br, input logic [1:0] j,
                        input logic z, input logic sg,
                        input logic [31:0] imm, input logic [31:0] alu,
                        input logic pt, input logic [31:0] ptg);
    ex_valid = v; ex_stall = s; ex_pc = pc; ex_branch = br; ex_jump = j;
    ex_zero = z; ex_sgn = sg; ex_pc_imm = imm; ex_alu_c = alu;
    ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic chk_redir(input string tag, input logic exp_r, input logic [31:0] exp_pc);
    check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, exp_r});
    if (exp_r) check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    idle_ex();
    #10;
    look("rst", 32'h100, 1'b0, 32'h104);
    chk_redir("rst", 1'b0, 32'h0);
`ifdef NPC_STATS_EN
    check("rst_stat_ctl", stat_ctl, 32'h0);
    check("rst_stat_mis", stat_mispred, 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // beq taken at 0x200, not predicted; same-cycle lookup sees old table
    if_pc = 32'h200;
    set_ex(1'b1, 1'b0, 32'h200, 3'b001, 2'b00, 1'b1, 1'b0, 32'h240, 32'h0, 1'b0, 32'h0);
    chk_redir("beq", 1'b1, 32'h240);
    check("beq_samecyc_taken", {31'd0, pred_taken}, 32'd0);
    tick();
    idle_ex();
    look("beq_after", 32'h200, 1'b1, 32'h240);

    // bne taken correctly predicted: ctr 10 -> 11
    set_ex(1'b1, 1'b0, 32'h200, 3'b011, 2'b00, 1'b0, 1'b0, 32'h240, 32'h0, 1'b1, 32'h240);
    chk_redir("bne_ok", 1'b0, 32'h0);
    tick();
    // not taken: 11 -> 10, still predicted taken
    set_ex(1'b1, 1'b0, 32'h200, 3'b011, 2'b00, 1'b1, 1'b0, 32'h240, 32'h0, 1'b1, 32'h240);
    chk_redir("bne_nt1", 1'b1, 32'h204);
    tick();
    idle_ex();
    look("bne_ctr10", 32'h200, 1'b1, 32'h240);
    // not taken again: 10 -> 01, now predicted not taken
    set_ex(1'b1, 1'b0, 32'h200, 3'b011, 2'b00, 1'b1, 1'b0, 32'h240, 32'h0, 1'b1, 32'h240);
    chk_redir("bne_nt2", 1'b1, 32'h204);
    tick();
    idle_ex();
    look("bne_ctr01", 32'h200, 1'b0, 32'h204);

    // jalr with odd rs1+imm: lsb cleared, pc_imm ignored
    set_ex(1'b1, 1'b0, 32'h300, 3'b000, 2'b01, 1'b0, 1'b0, 32'h9998, 32'h1235, 1'b0, 32'h0);
    chk_redir("jalr1", 1'b1, 32'h1234);
    tick();
    idle_ex();
    look("jalr1_after", 32'h300, 1'b1, 32'h1234);
    // jalr target changes: wrong target redirects and retrains
    set_ex(1'b1, 1'b0, 32'h300, 3'b000, 2'b01, 1'b0, 1'b0, 32'h9998, 32'h2000, 1'b1, 32'h1234);
    chk_redir("jalr2", 1'b1, 32'h2000);
    tick();
    idle_ex();
    look("jalr2_after", 32'h300, 1'b1, 32'h2000);
    // jal uses pc_imm, correctly predicted
    set_ex(1'b1, 1'b0, 32'h300, 3'b000, 2'b11, 1'b0, 1'b0, 32'h2000, 32'h55, 1'b1, 32'h2000);
    chk_redir("jal_ok", 1'b0, 32'h0);
    tick();

    // taken blt held 3 cycles by stall: redirect still asserted, no training
`ifdef NPC_STATS_EN
    ctl0 = stat_ctl;
    mis0 = stat_mispred;
`endif
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b1, 32'h410, 3'b101, 2'b00, 1'b0, 1'b1, 32'h480, 32'h0, 1'b0, 32'h0);
      chk_redir("stall", 1'b1, 32'h480);
      tick();
    end
    idle_ex();
    look("stall_notrain", 32'h410, 1'b0, 32'h414);
    set_ex(1'b1, 1'b0, 32'h410, 3'b101, 2'b00, 1'b0, 1'b1, 32'h480, 32'h0, 1'b0, 32'h0);
    tick();
    idle_ex();
    look("stall_train", 32'h410, 1'b1, 32'h480);
`ifdef NPC_STATS_EN
    check("stat_ctl_once", stat_ctl, ctl0 + 32'd1);
    check("stat_mis_once", stat_mispred, mis0 + 32'd1);
`endif
    // one not-taken blt must drop a single-trained entry (10) to not-taken
    set_ex(1'b1, 1'b0, 32'h410, 3'b101, 2'b00, 1'b0, 1'b0, 32'h480, 32'h0, 1'b1, 32'h480);
    chk_redir("blt_nt", 1'b1, 32'h414);
    tick();
    idle_ex();
    look("blt_once", 32'h410, 1'b0, 32'h414);

    // aliasing: 0x200 and 0x240 share index 0
    set_ex(1'b1, 1'b0, 32'h200, 3'b001, 2'b00, 1'b1, 1'b0, 32'h240, 32'h0, 1'b0, 32'h0);
    tick();
    idle_ex();
    look("alias_pre", 32'h200, 1'b1, 32'h240);
    set_ex(1'b1, 1'b0, 32'h240, 3'b111, 2'b00, 1'b0, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    chk_redir("bge", 1'b1, 32'h500);
    tick();
    idle_ex();
    look("alias_evict", 32'h200, 1'b0, 32'h204);
    look("alias_new", 32'h240, 1'b1, 32'h500);

    // non-control instruction: predicted taken must be undone, valid gates redirect
    set_ex(1'b1, 1'b0, 32'h600, 3'b000, 2'b00, 1'b1, 1'b1, 32'h700, 32'h0, 1'b1, 32'h700);
    chk_redir("nonctl", 1'b1, 32'h604);
    set_ex(1'b0, 1'b0, 32'h600, 3'b001, 2'b00, 1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    chk_redir("invalid", 1'b0, 32'h0);
    tick();
    idle_ex();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // asynchronous reset mid-cycle clears all predictions
    #2;
    rst_n = 1'b0;
    look("arst_0x240", 32'h240, 1'b0, 32'h244);
    look("arst_0x410", 32'h410, 1'b0, 32'h414);
    chk_redir("arst", 1'b0, 32'h0);
`ifdef NPC_STATS_EN
    check("arst_stat_ctl", stat_ctl, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_predictor.md
# npc_predictor

Parametrised next-PC unit for the pipelined miniRV core, replacing the purely combinational branch/jump resolver. It predicts the next PC in IF from a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It resolves the real outcome in EX using the existing branch/jump encodings, and raises a redirect on misprediction. It also trains the table on every resolved control-flow instruction.

## Interface
Parameters:
- XLEN, 32, datapath and PC width.
- ENTRIES, 16, BTB entries; power of two, ≥2. IDX = $clog2(ENTRIES).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- if_pc  in  XLEN  current fetch PC.
- pred_taken  out  1  IF prediction: next PC is pred_target.
- pred_target  out  XLEN  predicted next PC; if_pc+4 when not taken.
- ex_valid  in  1  EX holds a real instruction.
- ex_stall  in  1  EX held this cycle; suppresses training.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_branch  in  3  001 beq, 011 bne, 101 blt, 111 bge, other none.
- ex_jump  in  2  bit0 set = jal/jalr; 2'b01 = jalr.
- ex_zero, ex_sgn  in  1 each  ALU flags.
- ex_pc_imm  in  XLEN  pc+imm target (branch, jal).
- ex_alu_c  in  XLEN  rs1+imm (jalr).
- ex_pred_taken, ex_pred_target  in  1, XLEN  prediction piped from IF with this instruction.
- redirect  out  1  mispredict: flush IF/ID, load redirect_pc.
- redirect_pc  out  XLEN  corrected next PC.

## Operation
- Entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0], is_jump.
- Index: pc[IDX+1:2].
- Lookup (combinational on if_pc): hit = valid && tag match. pred_taken = hit && (is_jump || ctr[1]). pred_target = pred_taken ? target : if_pc+4.
- Resolve (combinational on EX inputs):
  - act_taken = 1 when ex_jump[0]. Otherwise, by branch code:
    - beq: zero.
    - bne: !zero.
    - blt: sgn.
    - bge: !sgn.
    - any other code: 0.
  - act_target = {ex_alu_c[XLEN-1:1],1'b0} when ex_jump==2'b01; otherwise ex_pc_imm.
- Mispredict when ex_valid && (act_taken != ex_pred_taken || (act_taken && act_target != ex_pred_target)).
- redirect_pc = act_taken ? act_target : ex_pc+4. redirect is gated by ex_valid only; ex_stall does not gate it.
- Training fires on an update event = ex_valid && !ex_stall && (ex_jump[0] || ex_branch[0]):
  - Taken, hit: target ← act_target; ctr saturating +1; is_jump ← ex_jump[0].
  - Taken, miss: allocate (overwrite). Fields: valid=1, tag, target. ctr=2'b11 for jumps, 2'b10 (weakly taken) for branches.
  - Not taken, hit: ctr saturating −1 (floors at 00).
  - Not taken, miss: no change.
- All arithmetic is modulo 2^XLEN; pc+4 wraps silently.

## Timing
- Lookup and resolve are zero-latency combinational. Table writes occur at the rising edge after the update event.
- Same cycle, same index for IF lookup and EX update: the lookup sees the pre-update contents.
- Stalled EX for N cycles: training happens exactly once, on the unstalled cycle.
- Reset, asynchronous, taken even mid-operation:
  - Every valid, ctr and is_jump clears to 0.
  - Outputs then read pred_taken=0 and pred_target=if_pc+4.
  - redirect follows its inputs and is 0 while ex_valid=0.
- Target/tag storage need not be reset.

## Configuration
- NPC_STATS_EN defined: adds outputs stat_ctl (32) and stat_mispred (32).
  - stat_ctl increments on each update event.
  - stat_mispred increments on each update event that also redirects.
  - Both reset to 0, wrap at 2^32 and saturate never.
- NPC_STATS_EN undefined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Package npc_pkg:
  - Branch codes BR_BEQ/BR_BNE/BR_BLT/BR_BGE.
  - Jump masks J_ANY/J_JALR.
  - Counter states CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - Entry struct typedef.
- Sub-module npc_resolve: combinational act_taken/act_target from the EX inputs; drop-in equivalent of the previous resolver.
- BTB storage and predict/train logic live in npc_predictor.

## Test plan
- After reset, if_pc=0x100 → pred_taken=0, pred_target=0x104; ex_valid=0 → redirect=0.
- beq at 0x200, zero=1, pc_imm=0x240, ex_pred_taken=0 → redirect=1, redirect_pc=0x240. Next cycle, if_pc=0x200 → pred_taken=1, pred_target=0x240 (ctr=10).
- Same bne trained to ctr=11, then resolved not-taken twice → ctr 10 then 01. Lookup → pred_taken=0. First of these resolves redirects to 0x204.
- jalr at 0x300, alu_c=0x1235 → redirect_pc=0x1234, entry is_jump=1. Repeat with alu_c=0x2000 and prediction 0x1234 → redirect=1, redirect_pc=0x2000.
- ex_stall=1 for 3 cycles on a taken branch → exactly one table update. With NPC_STATS_EN, stat_ctl advances by 1.
- Aliasing: a taken branch at 0x200 + ENTRIES*4 evicts the 0x200 entry. Then if_pc=0x200 → miss, pred_taken=0. rst_n pulsed low mid-run clears all predictions asynchronously.
